// File: rtl/quadrature_encode.sv
// Quadrature encoder: steps A/B (and a matching position count) toward a
// loaded target, one Gray-code step per `divider` clocks, taking the shorter
// way around the modulo-2^width circle.
module quadrature_encode #(
    parameter int unsigned width   = 8,
    parameter int unsigned divider = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] target,
    input  logic             load,
    output logic             A,
    output logic             B,
    output logic [width-1:0] position,
    output logic             busy
);

    localparam int unsigned CNT_W = (divider > 1) ? $clog2(divider) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(divider - 1);
    // Half of the circle: a difference of exactly this much still goes forward.
    localparam logic [width-1:0] HALF = {1'b1, {(width-1){1'b0}}};

    logic [width-1:0] pos_q, pos_d;
    logic [width-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic [width-1:0] diff;
    logic             fwd;
    logic             step;

    assign busy     = (pos_q != tgt_q);
    assign position = pos_q;
    assign A        = a_q;
    assign B        = b_q;

    // Next-state: target capture, direction choice, step pacing, phase outputs.
    always_comb begin
        tgt_d = tgt_q;
        pos_d = pos_q;
        cnt_d = cnt_q;
        diff  = tgt_q - pos_q;
        fwd   = (diff != '0) && (diff <= HALF);
        step  = busy && (cnt_q == CNT_MAX);

        // A load on a stepping edge only affects the following steps.
        if (load) begin
            tgt_d = target;
        end

        if (step) begin
            pos_d = fwd ? (pos_q + width'(1)) : (pos_q - width'(1));
        end

        // Idle parks the counter at its terminal value so a new move starts
        // on the very next edge.
        if (!busy) begin
            cnt_d = CNT_MAX;
        end else if (step) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        a_d = pos_d[1];
        b_d = pos_d[1] ^ pos_d[0];
    end

    // State register; reset aborts any motion in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= '0;
            tgt_q <= '0;
            cnt_q <= CNT_MAX;
            a_q   <= 1'b0;
            b_q   <= 1'b0;
        end else begin
            pos_q <= pos_d;
            tgt_q <= tgt_d;
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

endmodule

// File: tb/tb_quadrature_encode.sv
// Directed bench for quadrature_encode: per-edge vector table plus
// hand-written divider=1, reset-abort and decoder loopback sequences.
module tb_quadrature_encode;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst;
    logic [7:0] target;
    logic       load;
    logic       a, b, busy;
    logic [7:0] position;

    logic [7:0] target1;
    logic       load1;
    logic       a1, b1, busy1;
    logic [7:0] position1;

    int n_vec = 0;
    int n_bad = 0;

    quadrature_encode #(.width(8), .divider(4)) dut (
        .clk(clk), .rst(rst), .target(target), .load(load),
        .A(a), .B(b), .position(position), .busy(busy)
    );

    quadrature_encode #(.width(8), .divider(1)) dut1 (
        .clk(clk), .rst(rst), .target(target1), .load(load1),
        .A(a1), .B(b1), .position(position1), .busy(busy1)
    );

    // Free-running clock once enabled.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Reference quadrature decoder following the DUT's A/B.
    function automatic logic [1:0] gnext(input logic [1:0] s);
        case (s)
            2'b00:   gnext = 2'b01;
            2'b01:   gnext = 2'b11;
            2'b11:   gnext = 2'b10;
            default: gnext = 2'b00;
        endcase
    endfunction

    logic [1:0] dec_prev;
    logic [7:0] dec_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_prev <= 2'b00;
            dec_cnt  <= 8'd0;
        end else begin
            dec_prev <= {a, b};
            if ({a, b} == gnext(dec_prev))
                dec_cnt <= dec_cnt + 8'd1;
            else if (dec_prev == gnext({a, b}))
                dec_cnt <= dec_cnt - 8'd1;
        end
    end

    typedef struct {
        logic       ld;
        logic [7:0] tgt;
        int         edges;
        logic [1:0] ab;
        logic       bsy;
        logic [7:0] pos;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ld, input logic [7:0] tgt, input int edges,
                       input logic [1:0] ab, input logic bsy, input logic [7:0] pos);
        vec_t v;
        v.ld = ld; v.tgt = tgt; v.edges = edges;
        v.ab = ab; v.bsy = bsy; v.pos = pos;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h required %0h", nm, idx, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            load  = 1'b0;
            load1 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; target = 8'd0; load1 = 1'b0; target1 = 8'd0;

        // Vector table: {load, target, edges, expected AB, busy, position}.
        // forward 0 -> 3
        add(1, 8'd3,   1, 2'b00, 1, 8'd0);
        add(0, 8'd0,   1, 2'b01, 1, 8'd1);
        add(0, 8'd0,   3, 2'b01, 1, 8'd1);
        add(0, 8'd0,   1, 2'b11, 1, 8'd2);
        add(0, 8'd0,   3, 2'b11, 1, 8'd2);
        add(0, 8'd0,   1, 2'b10, 0, 8'd3);
        // backward 3 -> 1
        add(1, 8'd1,   1, 2'b10, 1, 8'd3);
        add(0, 8'd0,   1, 2'b11, 1, 8'd2);
        add(0, 8'd0,   3, 2'b11, 1, 8'd2);
        add(0, 8'd0,   1, 2'b01, 0, 8'd1);
        // back to 0
        add(1, 8'd0,   1, 2'b01, 1, 8'd1);
        add(0, 8'd0,   1, 2'b00, 0, 8'd0);
        // wrap both ways
        add(1, 8'd255, 1, 2'b00, 1, 8'd0);
        add(0, 8'd0,   1, 2'b10, 0, 8'd255);
        add(1, 8'd0,   1, 2'b10, 1, 8'd255);
        add(0, 8'd0,   1, 2'b00, 0, 8'd0);
        // load equal to position: nothing happens
        add(1, 8'd0,   1, 2'b00, 0, 8'd0);
        add(0, 8'd0,   4, 2'b00, 0, 8'd0);
        // half-circle tie goes forward, then retarget home
        add(1, 8'd128, 1, 2'b00, 1, 8'd0);
        add(0, 8'd0,   1, 2'b01, 1, 8'd1);
        add(1, 8'd0,   1, 2'b01, 1, 8'd1);
        add(0, 8'd0,   2, 2'b01, 1, 8'd1);
        add(0, 8'd0,   1, 2'b00, 0, 8'd0);
        // retarget 10 -> 0 after two steps, spacing kept
        add(1, 8'd10,  1, 2'b00, 1, 8'd0);
        add(0, 8'd0,   1, 2'b01, 1, 8'd1);
        add(0, 8'd0,   4, 2'b11, 1, 8'd2);
        add(1, 8'd0,   1, 2'b11, 1, 8'd2);
        add(0, 8'd0,   2, 2'b11, 1, 8'd2);
        add(0, 8'd0,   1, 2'b01, 1, 8'd1);
        add(0, 8'd0,   4, 2'b00, 0, 8'd0);
        // load on a stepping edge: that step still follows the old target
        add(1, 8'd2,   1, 2'b00, 1, 8'd0);
        add(0, 8'd0,   1, 2'b01, 1, 8'd1);
        add(0, 8'd0,   3, 2'b01, 1, 8'd1);
        add(1, 8'd0,   1, 2'b11, 1, 8'd2);
        add(0, 8'd0,   4, 2'b01, 1, 8'd1);
        add(0, 8'd0,   4, 2'b00, 0, 8'd0);

        // Asynchronous reset with the clock stopped.
        #2 rst = 1'b1;
        #1;
        chk("reset_async", 0, 32'({a, b, busy, position}), 32'd0);
        chk("reset_async", 1, 32'({a1, b1, busy1, position1}), 32'd0);

        clk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            load   = vecs[i].ld;
            target = vecs[i].tgt;
            tick(vecs[i].edges);
            chk("vec", i, 32'({a, b, busy, position}),
                32'({vecs[i].ab, vecs[i].bsy, vecs[i].pos}));
        end

        // divider=1: one step per clock.
        load1 = 1'b1; target1 = 8'd3;
        tick(1);
        chk("div1_load", 0, 32'({busy1, position1}), 32'({1'b1, 8'd0}));
        for (int s = 1; s <= 3; s++) begin
            tick(1);
            chk("div1_step", s, 32'(position1), 32'(s));
        end
        chk("div1_end", 0, 32'({a1, b1, busy1}), 32'({2'b10, 1'b0}));

        // Reset mid-motion aborts and stays idle afterwards.
        load = 1'b1; target = 8'd20;
        tick(6);
        chk("pre_abort", 0, 32'({busy, position}), 32'({1'b1, 8'd2}));
        rst = 1'b1;
        #1;
        chk("abort_async", 0, 32'({a, b, busy, position}), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(8);
        chk("abort_idle", 0, 32'({a, b, busy, position}), 32'd0);

        // Loopback through the reference decoder.
        begin
            logic [7:0] tl [3];
            tl[0] = 8'd5; tl[1] = 8'd2; tl[2] = 8'd250;
            for (int m = 0; m < 3; m++) begin
                int budget;
                load = 1'b1; target = tl[m];
                tick(1);
                budget = 0;
                while (busy && budget < 2000) begin
                    tick(1);
                    budget++;
                end
                if (busy) chk("loop_timeout", m, 32'(busy), 32'd0);
                tick(3);
                chk("loop_pos", m, 32'(position), 32'(tl[m]));
                chk("loop_dec", m, 32'(dec_cnt), 32'(tl[m]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/quadrature_encode.md
QUADRATURE_ENCODE -- requirements
Module: quadrature_encode

Interface
REQ-001 Parameter: width, default 8, bit width of target and position.
REQ-002 Parameter: divider, default 4, minimum clk cycles between successive A/B edges; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 target  input  width  desired position, sampled only when load=1.
REQ-006 load  input  1  when 1 at a rising clk edge, target_reg <= target.
REQ-007 A  output  1  quadrature channel A, driven directly from a flop.
REQ-008 B  output  1  quadrature channel B, driven directly from a flop.
REQ-009 position  output  width  count of net emitted edges, modulo 2^width.
REQ-010 busy  output  1  1 while position != target_reg.

Function
REQ-011 The phase mapping SHALL be fixed: position[1:0] 0->AB=00, 1->01, 2->11, 3->10, i.e. A=position[1], B=position[1]^position[0]; A and B update on the same edge as position.
REQ-012 A forward step SHALL increment position by 1 (AB 00->01->11->10->00); a backward step SHALL decrement it by 1 (reverse sequence); exactly one of A or B changes per step.
REQ-013 The step direction SHALL be evaluated each step from diff = (target_reg - position) mod 2^width: diff in 1..2^(width-1) -> forward, otherwise backward (tie at 2^(width-1) goes forward).
REQ-014 position SHALL wrap modulo 2^width in both directions (255+1=0, 0-1=255 for width 8).
REQ-015 A divider counter SHALL run 0..divider-1 while busy; a step is emitted on the edge where the counter equals divider-1 and busy=1; the counter returns to 0 on that edge.
REQ-016 While not busy, the counter SHALL hold at divider-1, so the first step follows a load by exactly one clk edge.
REQ-017 Latency: load at edge k with target != position -> busy=1 after edge k, first step at edge k+1, further steps at k+1+n*divider.
REQ-018 busy SHALL be combinationally position != target_reg and fall in the same cycle position reaches target_reg.
REQ-019 A load while busy SHALL replace target_reg without resetting the counter; the next step uses the new direction; spacing between steps never drops below divider cycles.
REQ-020 A load with target == position SHALL produce no step and leave busy=0.
REQ-021 Load and step on the same edge: the step uses the old target_reg; the new target_reg governs from the next edge.
REQ-022 divider=1 SHALL produce one step per clk cycle while busy.
REQ-023 Output must be decodable: with divider >= 4 and A/B looped into quadrature_decode of equal width on the same clk, its count SHALL equal position after settling.

Reset
REQ-024 rst=1 SHALL asynchronously force A=0, B=0, position=0, target_reg=0, busy=0, counter=divider-1, without a clk edge.
REQ-025 Reset asserted mid-motion SHALL abort the motion; after release no step occurs until the next load with a different target.

Verification
REQ-026 Reset: assert rst with clk stopped -> A=0, B=0, position=0, busy=0 immediately.
REQ-027 Forward: divider=4, load target=3 at edge k -> AB=01 at k+1, 11 at k+5, 10 at k+9; position=3; busy falls after k+9.
REQ-028 Backward: from position 3, load target=1 -> AB=11 then 01, spaced 4 cycles; position=1; busy=0.
REQ-029 Wrap: width=8, position 0, load 255 -> single backward step, AB=10, position=255; then load 0 -> single forward step, AB=00.
REQ-030 Retarget: load 10, after 2 steps load 0 -> direction reverses, 2 backward steps, end at position 0, no step gap under 4 cycles.
REQ-031 Loopback: drive quadrature_decode (width 8) from A/B with divider=4 through loads 5, 2, 250 -> decoder count equals position after each move.
